// File: rtl/task_dispatcher_pkg.sv
// Shared types and helpers for the task dispatcher: FSM state encoding,
// width helpers and the rotating lowest-set-bit picker used by both arbiters.
package task_dispatcher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BOOT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int MAX_PROCS = 32;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } pick_t;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Lowest set bit of mask at or after ptr, wrapping at n (n <= MAX_PROCS).
  function automatic pick_t rr_pick(input logic [MAX_PROCS-1:0] mask,
                                    input int ptr, input int n);
    pick_t r;
    int    idx;
    r = '0;
    for (int k = 0; k < MAX_PROCS; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if ((k < n) && !r.found && mask[idx[4:0]]) begin
        r.found = 1'b1;
        r.idx   = idx[4:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/task_dispatcher_fifo.sv
// Show-ahead FIFO holding queued task addresses; pointers carry an extra
// wrap bit so full and empty are distinguished without a separate counter.
module dispatch_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign dout    = mem[rd_ptr[AW-1:0]];
  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !reset && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/task_dispatcher.sv
// Task dispatcher: queues spawned task addresses and launches them on free
// processors with round-robin fairness; boots the first task and detects completion.
//
// state | meaning
// IDLE  | waiting for start after reset
// BOOT  | one cycle, issues the boot launch to processor 0
// RUN   | accepting spawns, launching queued tasks, watching for termination
// DONE  | all work finished; left only by reset or a new start
module task_dispatcher
  import task_dispatcher_pkg::*;
#(
  parameter int                PROC_CNT    = 4,
  parameter int                ADDR_W      = 8,
  parameter int                QUEUE_DEPTH = 16,
  parameter logic [ADDR_W-1:0] BOOT_ADDR   = '0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [PROC_CNT-1:0]          spawn_valid,
  input  logic [PROC_CNT*ADDR_W-1:0]   spawn_addr,
  output logic [PROC_CNT-1:0]          spawn_ready,
  input  logic [PROC_CNT-1:0]          busy,
  output logic [PROC_CNT-1:0]          launch,
  output logic [ADDR_W-1:0]            launch_addr,
  output logic [$clog2(QUEUE_DEPTH):0] queue_level,
  output logic                         running,
  output logic                         done
);

  localparam int PTR_W = ptr_w(PROC_CNT);
  localparam int LVL_W = lvl_w(QUEUE_DEPTH);

  state_t              state, state_next;
  logic [PTR_W-1:0]    spawn_ptr, spawn_ptr_next;
  logic [PTR_W-1:0]    launch_ptr, launch_ptr_next;
  logic [PROC_CNT-1:0] pending, pending_next;
  logic [PROC_CNT-1:0] free;
  logic [PROC_CNT-1:0] launch_next;
  logic [ADDR_W-1:0]   launch_addr_next;
  pick_t               spawn_pick, launch_pick;

  logic              fifo_flush, fifo_push, fifo_pop;
  logic              fifo_full, fifo_empty;
  logic [ADDR_W-1:0] fifo_din, fifo_dout;
  logic [LVL_W-1:0]  fifo_level;

  dispatch_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (ADDR_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (fifo_flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign queue_level = fifo_level;
  assign running     = (state == BOOT) || (state == RUN);
  assign done        = (state == DONE);
  assign free        = ~busy & ~pending;

  always_comb begin
    state_next       = state;
    spawn_ready      = '0;
    fifo_flush       = 1'b0;
    fifo_push        = 1'b0;
    fifo_pop         = 1'b0;
    fifo_din         = '0;
    spawn_ptr_next   = spawn_ptr;
    launch_ptr_next  = launch_ptr;
    // A processor seen busy has picked up its launch; its pending flag retires.
    pending_next     = pending & ~busy;
    launch_next      = '0;
    launch_addr_next = '0;
    spawn_pick       = rr_pick(MAX_PROCS'(spawn_valid), int'(spawn_ptr), PROC_CNT);
    launch_pick      = rr_pick(MAX_PROCS'(free), int'(launch_ptr), PROC_CNT);

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next   = BOOT;
          fifo_flush   = 1'b1;
          pending_next = '0;
        end
      end
      BOOT: begin
        state_next       = RUN;
        launch_next[0]   = 1'b1;
        launch_addr_next = BOOT_ADDR;
        pending_next[0]  = 1'b1;
      end
      RUN: begin
        fifo_pop = !fifo_empty && launch_pick.found;
        if (fifo_pop) begin
          for (int i = 0; i < PROC_CNT; i++) begin
            if (i == int'(launch_pick.idx)) begin
              launch_next[i]  = 1'b1;
              pending_next[i] = 1'b1;
            end
          end
          launch_addr_next = fifo_dout;
          launch_ptr_next  = PTR_W'((int'(launch_pick.idx) + 1) % PROC_CNT);
        end
        // A full queue still takes a spawn when its head is leaving this cycle.
        if (spawn_pick.found && (!fifo_full || fifo_pop)) begin
          fifo_push = 1'b1;
          for (int i = 0; i < PROC_CNT; i++) begin
            if (i == int'(spawn_pick.idx)) begin
              spawn_ready[i] = 1'b1;
              fifo_din       = spawn_addr[i*ADDR_W +: ADDR_W];
            end
          end
          spawn_ptr_next = PTR_W'((int'(spawn_pick.idx) + 1) % PROC_CNT);
        end
        if (fifo_empty && (busy == '0) && (pending == '0) && (spawn_valid == '0))
          state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      spawn_ptr   <= '0;
      launch_ptr  <= '0;
      pending     <= '0;
      launch      <= '0;
      launch_addr <= '0;
    end else begin
      state       <= state_next;
      spawn_ptr   <= spawn_ptr_next;
      launch_ptr  <= launch_ptr_next;
      pending     <= pending_next;
      launch      <= launch_next;
      launch_addr <= launch_addr_next;
    end
  end

endmodule

// File: tb/tb_task_dispatcher.sv
// Directed bench for task_dispatcher: boot/termination, fan-out, round-robin
// spawn order, full-queue backpressure, pending guard and mid-run reset.
module tb_task_dispatcher;

  localparam int PROC_CNT    = 4;
  localparam int ADDR_W      = 8;
  localparam int QUEUE_DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  spawn_valid;
  logic [31:0] spawn_addr;
  logic [3:0]  spawn_ready;
  logic [3:0]  busy;
  logic [3:0]  launch;
  logic [7:0]  launch_addr;
  logic [2:0]  queue_level;
  logic        running;
  logic        done;

  int passed = 0;
  int total  = 0;

  task_dispatcher #(
    .PROC_CNT    (PROC_CNT),
    .ADDR_W      (ADDR_W),
    .QUEUE_DEPTH (QUEUE_DEPTH),
    .BOOT_ADDR   (8'h10)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .spawn_valid (spawn_valid),
    .spawn_addr  (spawn_addr),
    .spawn_ready (spawn_ready),
    .busy        (busy),
    .launch      (launch),
    .launch_addr (launch_addr),
    .queue_level (queue_level),
    .running     (running),
    .done        (done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; spawn_valid = '0; spawn_addr = '0; busy = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_launch", 32'(launch), 0);
    chk("rst_addr", 32'(launch_addr), 0);
    chk("rst_level", 32'(queue_level), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ready", 32'(spawn_ready), 0);

    // boot and idle termination
    start = 1'b1; tick(); start = 1'b0;
    chk("boot_running", 32'(running), 1);
    chk("boot_nolaunch", 32'(launch), 0);
    tick();
    chk("boot_launch", 32'(launch), 4'b0001);
    chk("boot_addr", 32'(launch_addr), 8'h10);
    busy = 4'b0001;
    tick(); chk("busy_nolaunch", 32'(launch), 0);
    tick(); tick();
    busy = 4'b0000;
    chk("done_not_yet", 32'(done), 0);
    tick();
    chk("done_rise", 32'(done), 1);
    chk("done_running", 32'(running), 0);
    tick();
    chk("done_hold", 32'(done), 1);

    // fan-out from proc 0
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("fan_boot", 32'(launch), 4'b0001);
    busy = 4'b0001;
    tick();
    spawn_valid = 4'b0001; spawn_addr[7:0] = 8'hA1;
    #1 chk("fan_ready", 32'(spawn_ready), 4'b0001);
    tick();
    chk("fan_lvl1", 32'(queue_level), 1);
    chk("fan_nolaunch", 32'(launch), 0);
    spawn_addr[7:0] = 8'hA2;
    tick();
    chk("fan_l1", 32'(launch), 4'b0010);
    chk("fan_a1", 32'(launch_addr), 8'hA1);
    chk("fan_lvl_a", 32'(queue_level), 1);
    spawn_addr[7:0] = 8'hA3;
    tick();
    chk("fan_l2", 32'(launch), 4'b0100);
    chk("fan_a2", 32'(launch_addr), 8'hA2);
    spawn_valid = '0;
    tick();
    chk("fan_l3", 32'(launch), 4'b1000);
    chk("fan_a3", 32'(launch_addr), 8'hA3);
    chk("fan_lvl0", 32'(queue_level), 0);
    chk("fan_notdone", 32'(done), 0);

    // fresh run: round-robin spawn order and full backpressure
    reset = 1'b1; busy = '0; tick(); reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    busy = 4'b1111;
    tick();
    spawn_valid = 4'b1111;
    spawn_addr  = {8'h03, 8'h02, 8'h01, 8'h00};
    #1 chk("rr_g0", 32'(spawn_ready), 4'b0001);
    tick(); spawn_addr[7:0] = 8'h04;
    #1 chk("rr_g1", 32'(spawn_ready), 4'b0010);
    tick(); spawn_addr[15:8] = 8'h05;
    #1 chk("rr_g2", 32'(spawn_ready), 4'b0100);
    tick();
    #1 chk("rr_g3", 32'(spawn_ready), 4'b1000);
    tick();
    chk("full_level", 32'(queue_level), 4);
    chk("full_ready0", 32'(spawn_ready), 0);
    tick();
    chk("full_hold_ready", 32'(spawn_ready), 0);
    chk("full_hold_level", 32'(queue_level), 4);
    busy = 4'b1110;
    #1 chk("full_pushpop_ready", 32'(spawn_ready), 4'b0001);
    tick();
    chk("full_pop_launch", 32'(launch), 4'b0001);
    chk("fifo_head00", 32'(launch_addr), 8'h00);
    chk("full_pushpop_level", 32'(queue_level), 4);
    chk("full_ready_again0", 32'(spawn_ready), 0);
    spawn_valid = '0;
    busy = 4'b1111;
    tick();

    // pending guard: only proc 2 idle, it receives one task and no more
    busy = 4'b1011;
    tick();
    chk("guard_launch", 32'(launch), 4'b0100);
    chk("fifo_head01", 32'(launch_addr), 8'h01);
    chk("guard_level", 32'(queue_level), 3);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("guard_nolaunch", 32'(launch), 0);
      chk("guard_notdone", 32'(done), 0);
      chk("guard_level_hold", 32'(queue_level), 3);
    end

    // reset mid-run with queued work and pending processors
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mrst_launch", 32'(launch), 0);
    chk("mrst_addr", 32'(launch_addr), 0);
    chk("mrst_level", 32'(queue_level), 0);
    chk("mrst_running", 32'(running), 0);
    chk("mrst_done", 32'(done), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mrst_idle_nolaunch", 32'(launch), 0);
      chk("mrst_idle_running", 32'(running), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
